// File: rtl/scroll_line_fetcher.sv
// Fetches the next line's 9-bit X-scroll values for layers A and B from the scroll RAM
// during horizontal blank, and commits them to the tilemap address generators at line start.
module scroll_line_fetcher #(
  parameter logic [10:0] BASE_A = 11'h000,
  parameter logic [10:0] BASE_B = 11'h400,
  parameter logic [10:0] HI_OFS = 11'h200
) (
  input  logic        i_MCLK,
  input  logic        i_RST_n,
  input  logic        i_HBLANK_START,
  input  logic        i_LINE_START,
  input  logic [7:0]  i_VCOUNT,
  input  logic        i_CPU_REQ,
  output logic [10:0] o_SCR_ADDR,
  output logic        o_SCR_RD_n,
  input  logic [7:0]  i_SCR_DOUT,
  output logic [8:0]  o_SCROLLX_A,
  output logic [8:0]  o_SCROLLX_B,
  output logic        o_MISS
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_A_LO = 3'd1,
    S_A_HI = 3'd2,
    S_B_LO = 3'd3,
    S_B_HI = 3'd4,
    S_CAP  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SEL_A_LO = 2'd0,
    SEL_A_HI = 2'd1,
    SEL_B_LO = 2'd2,
    SEL_B_HI = 2'd3
  } byte_sel_t;

  state_t    state_q, state_d;
  logic [7:0] line_q, line_d;
  logic       done_q, done_d;
  logic       pend_vld_q, pend_vld_d;
  byte_sel_t  pend_sel_q, pend_sel_d;
  logic [7:0] shd_a_lo_q, shd_a_lo_d;
  logic       shd_a_hi_q, shd_a_hi_d;
  logic [7:0] shd_b_lo_q, shd_b_lo_d;
  logic       shd_b_hi_q, shd_b_hi_d;
  logic [8:0] scroll_a_q, scroll_a_d;
  logic [8:0] scroll_b_q, scroll_b_d;
  logic       miss_q, miss_d;

  logic        fetch_active;
  logic        rd_accept;
  logic [10:0] line_ofs;
  logic [10:0] addr_c;

  assign line_ofs = {3'b000, line_q};

  // The read strobe reacts to the CPU request in the same cycle so the CPU never waits.
  always_comb begin
    fetch_active = (state_q == S_A_LO) || (state_q == S_A_HI) ||
                   (state_q == S_B_LO) || (state_q == S_B_HI);
    rd_accept    = fetch_active && !i_CPU_REQ;
  end

  always_comb begin
    addr_c = 11'h000;
    case (state_q)
      S_A_LO:  addr_c = BASE_A + line_ofs;
      S_A_HI:  addr_c = BASE_A + HI_OFS + line_ofs;
      S_B_LO:  addr_c = BASE_B + line_ofs;
      S_B_HI:  addr_c = BASE_B + HI_OFS + line_ofs;
      default: addr_c = 11'h000;
    endcase
  end

  assign o_SCR_ADDR  = addr_c;
  assign o_SCR_RD_n  = !rd_accept;
  assign o_SCROLLX_A = scroll_a_q;
  assign o_SCROLLX_B = scroll_b_q;
  assign o_MISS      = miss_q;

  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    done_d     = done_q;
    pend_vld_d = 1'b0;
    pend_sel_d = pend_sel_q;
    shd_a_lo_d = shd_a_lo_q;
    shd_a_hi_d = shd_a_hi_q;
    shd_b_lo_d = shd_b_lo_q;
    shd_b_hi_d = shd_b_hi_q;
    scroll_a_d = scroll_a_q;
    scroll_b_d = scroll_b_q;
    miss_d     = 1'b0;

    // RAM data lands one cycle after the accepted read, independent of CPU stalls.
    if (pend_vld_q) begin
      case (pend_sel_q)
        SEL_A_LO: shd_a_lo_d = i_SCR_DOUT;
        SEL_A_HI: shd_a_hi_d = i_SCR_DOUT[0];
        SEL_B_LO: shd_b_lo_d = i_SCR_DOUT;
        SEL_B_HI: shd_b_hi_d = i_SCR_DOUT[0];
        default:  shd_a_lo_d = shd_a_lo_q;
      endcase
    end

    if (rd_accept) begin
      pend_vld_d = 1'b1;
      case (state_q)
        S_A_LO: begin
          pend_sel_d = SEL_A_LO;
          state_d    = S_A_HI;
        end
        S_A_HI: begin
          pend_sel_d = SEL_A_HI;
          state_d    = S_B_LO;
        end
        S_B_LO: begin
          pend_sel_d = SEL_B_LO;
          state_d    = S_B_HI;
        end
        default: begin
          pend_sel_d = SEL_B_HI;
          state_d    = S_CAP;
        end
      endcase
    end

    if (state_q == S_CAP) begin
      done_d  = 1'b1;
      state_d = S_IDLE;
    end

    // Evaluated on the old done flag: a capture landing on this same edge is a miss.
    if (i_LINE_START) begin
      if (done_q) begin
        scroll_a_d = {shd_a_hi_q, shd_a_lo_q};
        scroll_b_d = {shd_b_hi_q, shd_b_lo_q};
        done_d     = 1'b0;
      end else begin
        miss_d = 1'b1;
      end
    end

    // A new blank wins over everything; any in-flight read data is dropped.
    if (i_HBLANK_START) begin
      line_d     = i_VCOUNT + 8'd1;
      done_d     = 1'b0;
      state_d    = S_A_LO;
      pend_vld_d = 1'b0;
      shd_a_lo_d = 8'h00;
      shd_a_hi_d = 1'b0;
      shd_b_lo_d = 8'h00;
      shd_b_hi_d = 1'b0;
    end
  end

  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q    <= S_IDLE;
      line_q     <= 8'h00;
      done_q     <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_sel_q <= SEL_A_LO;
      shd_a_lo_q <= 8'h00;
      shd_a_hi_q <= 1'b0;
      shd_b_lo_q <= 8'h00;
      shd_b_hi_q <= 1'b0;
      scroll_a_q <= 9'h000;
      scroll_b_q <= 9'h000;
      miss_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      done_q     <= done_d;
      pend_vld_q <= pend_vld_d;
      pend_sel_q <= pend_sel_d;
      shd_a_lo_q <= shd_a_lo_d;
      shd_a_hi_q <= shd_a_hi_d;
      shd_b_lo_q <= shd_b_lo_d;
      shd_b_hi_q <= shd_b_hi_d;
      scroll_a_q <= scroll_a_d;
      scroll_b_q <= scroll_b_d;
      miss_q     <= miss_d;
    end
  end

  // Completed values only ever wait in IDLE; pending captures only follow a fetch state.
  a_done_idle: assert property (@(posedge i_MCLK) disable iff (!i_RST_n)
    done_q |-> (state_q == S_IDLE));
  a_pend_busy: assert property (@(posedge i_MCLK) disable iff (!i_RST_n)
    pend_vld_q |-> (state_q != S_IDLE));

endmodule

// File: tb/tb_scroll_line_fetcher.sv
// Directed bench for scroll_line_fetcher with a behavioural scroll RAM (registered read).
module tb_scroll_line_fetcher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hblank = 1'b0;
  logic        line_start = 1'b0;
  logic [7:0]  vcount = 8'h00;
  logic        cpu_req = 1'b0;
  logic [10:0] addr;
  logic        rd_n;
  logic [7:0]  dout = 8'h00;
  logic [8:0]  scroll_a;
  logic [8:0]  scroll_b;
  logic        miss;

  logic [7:0] mem [0:2047];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rd_n) dout <= mem[addr];
  end

  scroll_line_fetcher dut (
    .i_MCLK         (clk),
    .i_RST_n        (rst_n),
    .i_HBLANK_START (hblank),
    .i_LINE_START   (line_start),
    .i_VCOUNT       (vcount),
    .i_CPU_REQ      (cpu_req),
    .o_SCR_ADDR     (addr),
    .o_SCR_RD_n     (rd_n),
    .i_SCR_DOUT     (dout),
    .o_SCROLLX_A    (scroll_a),
    .o_SCROLLX_B    (scroll_b),
    .o_MISS         (miss)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_hblank(input logic [7:0] vc);
    vcount = vc;
    hblank = 1'b1;
    tick();
    hblank = 1'b0;
  endtask

  task automatic pulse_line();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [10:0] exp_addr [4];
    int lows;

    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    mem[11'h005] = 8'h34; mem[11'h205] = 8'h01; mem[11'h405] = 8'hA0; mem[11'h605] = 8'hFE;
    mem[11'h000] = 8'h11; mem[11'h200] = 8'h00; mem[11'h400] = 8'h55; mem[11'h600] = 8'h03;
    mem[11'h011] = 8'h77; mem[11'h211] = 8'hFF; mem[11'h411] = 8'h3C; mem[11'h611] = 8'h00;
    mem[11'h021] = 8'h99; mem[11'h221] = 8'h00; mem[11'h421] = 8'h42; mem[11'h621] = 8'h01;
    mem[11'h031] = 8'hEE; mem[11'h231] = 8'h01; mem[11'h431] = 8'hDD; mem[11'h631] = 8'h01;
    mem[11'h00A] = 8'h5A; mem[11'h20A] = 8'h01; mem[11'h40A] = 8'hC3; mem[11'h60A] = 8'h00;
    mem[11'h041] = 8'h22; mem[11'h241] = 8'h01; mem[11'h441] = 8'h07; mem[11'h641] = 8'h00;

    // Reset state
    ticks(2);
    check("rst_scroll_a", scroll_a, 9'h000);
    check("rst_scroll_b", scroll_b, 9'h000);
    check("rst_rd_n", rd_n, 1'b1);
    check("rst_addr", addr, 11'h000);
    check("rst_miss", miss, 1'b0);
    rst_n = 1'b1;
    ticks(2);

    // Basic fetch, line 5
    exp_addr = '{11'h005, 11'h205, 11'h405, 11'h605};
    lows = 0;
    pulse_hblank(8'h04);
    for (int i = 0; i < 6; i++) begin
      if (!rd_n) lows++;
      if (i < 4) check($sformatf("t1_addr%0d", i), addr, exp_addr[i]);
      tick();
    end
    check("t1_rd_low_cycles", lows, 4);
    pulse_line();
    check("t1_scroll_a", scroll_a, 9'h134);
    check("t1_scroll_b", scroll_b, 9'h0A0);
    check("t1_miss", miss, 1'b0);

    // Line number wraps 255 -> 0
    pulse_hblank(8'hFF);
    check("t2_addr", addr, 11'h000);
    check("t2_rd_n", rd_n, 1'b0);
    ticks(5);
    pulse_line();
    check("t2_scroll_a", scroll_a, 9'h011);
    check("t2_scroll_b", scroll_b, 9'h155);

    // CPU stall after the second accepted read
    pulse_hblank(8'h10);
    ticks(2);
    cpu_req = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_stall_rd_n%0d", i), rd_n, 1'b1);
      check($sformatf("t3_stall_addr%0d", i), addr, 11'h411);
      tick();
    end
    cpu_req = 1'b0;
    #1;
    check("t3_resume_rd_n", rd_n, 1'b0);
    check("t3_resume_addr", addr, 11'h411);
    tick();
    check("t3_b_hi_addr", addr, 11'h611);
    tick();
    check("t3_cap_rd_n", rd_n, 1'b1);
    tick();
    pulse_line();
    check("t3_miss", miss, 1'b0);
    check("t3_scroll_a", scroll_a, 9'h177);
    check("t3_scroll_b", scroll_b, 9'h03C);

    // Line start before fetch completes
    pulse_hblank(8'h20);
    ticks(2);
    pulse_line();
    check("t4_miss_pulse", miss, 1'b1);
    check("t4_hold_a", scroll_a, 9'h177);
    check("t4_hold_b", scroll_b, 9'h03C);
    tick();
    check("t4_miss_clear", miss, 1'b0);
    tick();
    pulse_line();
    check("t4_late_miss", miss, 1'b0);
    check("t4_late_a", scroll_a, 9'h099);
    check("t4_late_b", scroll_b, 9'h142);

    // Restart during B_LO
    pulse_hblank(8'h30);
    ticks(2);
    check("t5_b_lo_addr", addr, 11'h431);
    pulse_hblank(8'h09);
    check("t5_restart_addr", addr, 11'h00A);
    check("t5_restart_rd_n", rd_n, 1'b0);
    ticks(5);
    // Simultaneous line start and blank start: commit old result, then restart
    vcount = 8'h40;
    hblank = 1'b1;
    line_start = 1'b1;
    tick();
    hblank = 1'b0;
    line_start = 1'b0;
    check("t5_both_a", scroll_a, 9'h15A);
    check("t5_both_b", scroll_b, 9'h0C3);
    check("t5_both_miss", miss, 1'b0);
    check("t5_both_addr", addr, 11'h041);
    ticks(5);
    pulse_line();
    check("t5_next_a", scroll_a, 9'h122);
    check("t5_next_b", scroll_b, 9'h007);

    // Asynchronous reset during A_HI
    pulse_hblank(8'h50);
    tick();
    check("t6_pre_rd_n", rd_n, 1'b0);
    check("t6_pre_addr", addr, 11'h251);
    rst_n = 1'b0;
    #1;
    check("t6_rst_a", scroll_a, 9'h000);
    check("t6_rst_b", scroll_b, 9'h000);
    check("t6_rst_rd_n", rd_n, 1'b1);
    check("t6_rst_addr", addr, 11'h000);
    check("t6_rst_miss", miss, 1'b0);
    tick();
    rst_n = 1'b1;
    ticks(2);
    check("t6_idle_rd_n", rd_n, 1'b1);
    check("t6_idle_addr", addr, 11'h000);
    pulse_line();
    check("t6_idle_miss", miss, 1'b1);
    check("t6_idle_a", scroll_a, 9'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
